p405s_apu_issue_model: RTL
==========================

// Module: p405s_apu_issue_model
// PURPOSE
//  C405-side initiator of the APU interface: the processor end that drives the APU shell.
//  Queues 32-bit instructions and presents each in decode; advances ValidOp ones to EXE.
//  Supplies RA/RB operands from a local GPR file and captures CR6 results.
//  Used in ver_shell benches and FPGA bring-up to drive the AltiVec path without a CPU core.
// PARAMETERS
//  FIFO_DEPTH   8    instruction queue entries (power of 2, >=2)
//  CNT_W        16   width of issue/reject/busy counters
// PORTS
//  clk                     in   1   system clock
//  rst                     in   1   reset, asynchronous, active-high
//  ins_push_valid          in   1   instruction push request
//  ins_push_data           in   32  instruction word [0:31]
//  ins_push_ready          out  1   queue not full
//  gpr_wr_en/addr/data     in   1/5/32  local GPR write port (debug preload)
//  hold_req                in   1   external decode stall request
//  flush_req               in   1   flush instruction in EXE
//  C405_apuDcdInstruction  out  32  instruction in decode
//  C405_apuDcdFull         out  1   decode slot occupied
//  C405_apuDcdHold         out  1   decode instruction must not advance
//  C405_apuExeHold         out  1   EXE held (tied 0 in this revision)
//  C405_apuExeFlush        out  1   EXE flushed this cycle
//  C405_apuExeRaData       out  32  RA operand in EXE
//  C405_apuExeRbData       out  32  RB operand in EXE
//  APU_c405DcdValidOp      in   1   APU accepts decode instruction
//  APU_c405DcdRaEn/RbEn    in   1/1 operand read enables (decode)
//  APU_c405DcdCREn         in   1   instruction records CR (decode)
//  APU_c405ExeCRField      in   3   CR field number (expected 6)
//  APU_c405ExeBusy         in   1   APU cannot accept a new instruction
//  APU_c405ExeCR           in   4   CR result in EXE
//  cr6_value               out  4   last captured CR6
//  issue_cnt/reject_cnt/busy_cnt  out  CNT_W each  saturating counters
//  idle                    out  1   queue, DCD and EXE all empty
// BEHAVIOUR
//  - Reset: all outputs 0, queue empty, ins_push_ready=1, idle=1. GPR file is not reset.
//  - Queue: push when valid&ready. Pop into DCD when DCD is empty or DCD advances/rejects that cycle.
//  - Push and pop in the same cycle while full are allowed; occupancy is unchanged.
//  - DCD register (valid, instr): DcdFull=dcd_valid. DcdInstruction=instr; drives 0 when empty.
//  - DcdHold = dcd_valid & (ExeBusy | hold_req).
//  - advance = dcd_valid & ValidOp & !DcdHold: next cycle EXE loads instr plus latched RaEn/RbEn/CREn.
//    issue_cnt increments on advance.
//  - reject = dcd_valid & !ValidOp & !hold_req: DCD drops the instruction and reject_cnt increments.
//    Non-APU ops never stall the model.
//  - busy_cnt increments each cycle that dcd_valid & ExeBusy.
//  - EXE: one-cycle stage. RaData=gpr[instr[11:15]] if ra_en, else 0; RbData=gpr[instr[16:20]] if rb_en, else 0.
//    EXE drives 0 when empty.
//  - GPR bypass: a gpr write to the same address in the EXE-load cycle is forwarded.
//  - CR capture: exe_valid & cr_en & !flush_req & CRField==6 -> cr6_value<=ExeCR at end of EXE cycle.
//    CRField!=6 is ignored.
//  - Flush: flush_req while exe_valid -> ExeFlush=1 that cycle, EXE invalidated, no CR capture.
//    issue_cnt is not decremented. flush_req with EXE empty: ExeFlush=0. DCD is unaffected.
//  - Counters saturate at all-ones.
//  - rst mid-operation: queue, DCD, EXE and counters clear immediately (async). Outputs return to reset values.
//  - Latency: push -> DcdFull is 1 cycle (empty pipe); advance -> EXE operands is 1 cycle.
// STRUCTURE
//  - Shared package p405s_apu_pkg: CR6_FIELD=3'd6, RA_LSB/RB_LSB instruction field positions, VX opcode constant 6'd4.
//  - Sub-module p405s_apu_ins_fifo (parameterised sync FIFO, async active-high reset).
//  - Top level holds the DCD/EXE registers, GPR array (32x32) and counters.
// TESTING
//  - Push 0x10000000 (VX), ValidOp=1 in DCD, RaEn=1, gpr[0]=0x11111111.
//    -> DcdFull 1 cycle after push; ExeRaData=0x11111111 next cycle; issue_cnt=1.
//  - ExeBusy=1 for 5 cycles with DCD full.
//    -> DcdHold=1 for those 5 cycles, instruction stable; busy_cnt=5; advances on the 1st cycle ExeBusy=0.
//  - Push 0x7C000214 (non-APU), ValidOp=0.
//    -> dropped after 1 DCD cycle; reject_cnt=1; next queued op enters DCD the following cycle.
//  - Vector compare with CREn=1, ExeCR=4'b1000, CRField=6.
//    -> cr6_value=4'b1000. Repeat with flush_req in EXE -> ExeFlush=1, cr6_value unchanged.
//  - Push 9 words into FIFO_DEPTH=8 with DCD held.
//    -> ready=0 after the 8 queued plus 1 in DCD; no loss, issue order preserved.
//  - Assert rst with all stages full.
//    -> idle=1, DcdFull=0, counters=0 in the same cycle, before the next clk edge.

Source files
------------

// File: rtl/p405s_apu_pkg.sv
// Shared constants for the C405-side APU issue model.
// RA/RB positions are vector LSBs of PowerPC fields [11:15] and [16:20].
package p405s_apu_pkg;
  localparam logic [2:0] CR6_FIELD = 3'd6;
  localparam int         RA_LSB    = 16;
  localparam int         RB_LSB    = 11;
  localparam logic [5:0] VX_OPCODE = 6'd4;

  function automatic logic [4:0] gpr_field(input logic [31:0] instr, input int lsb);
    return instr[lsb +: 5];
  endfunction
endpackage

// File: rtl/p405s_apu_ins_fifo.sv
// Synchronous instruction FIFO; occupancy counter disambiguates full/empty.
// The caller never pushes into a full FIFO unless it pops in the same cycle.
module p405s_apu_ins_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
endmodule

// File: rtl/p405s_apu_issue_model.sv
// Processor-side APU initiator: queues instructions, presents them in decode,
// advances accepted ones to a one-cycle EXE stage with GPR operands, captures CR6.
module p405s_apu_issue_model
  import p405s_apu_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ins_push_valid,
  input  logic [31:0]      ins_push_data,
  output logic             ins_push_ready,
  input  logic             gpr_wr_en,
  input  logic [4:0]       gpr_wr_addr,
  input  logic [31:0]      gpr_wr_data,
  input  logic             hold_req,
  input  logic             flush_req,
  output logic [31:0]      C405_apuDcdInstruction,
  output logic             C405_apuDcdFull,
  output logic             C405_apuDcdHold,
  output logic             C405_apuExeHold,
  output logic             C405_apuExeFlush,
  output logic [31:0]      C405_apuExeRaData,
  output logic [31:0]      C405_apuExeRbData,
  input  logic             APU_c405DcdValidOp,
  input  logic             APU_c405DcdRaEn,
  input  logic             APU_c405DcdRbEn,
  input  logic             APU_c405DcdCREn,
  input  logic [2:0]       APU_c405ExeCRField,
  input  logic             APU_c405ExeBusy,
  input  logic [3:0]       APU_c405ExeCR,
  output logic [3:0]       cr6_value,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] reject_cnt,
  output logic [CNT_W-1:0] busy_cnt,
  output logic             idle
);
  logic             fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic [31:0]      fifo_data;
  logic             dcd_valid_q, dcd_valid_d, exe_valid_q, exe_valid_d;
  logic [31:0]      dcd_instr_q, dcd_instr_d;
  logic             exe_cr_en_q, exe_cr_en_d;
  logic [31:0]      exe_ra_q, exe_ra_d, exe_rb_q, exe_rb_d;
  logic [3:0]       cr6_q, cr6_d;
  logic [CNT_W-1:0] issue_q, issue_d, reject_q, reject_d, busy_q, busy_d;
  logic [31:0]      gpr_q [32];
  logic             dcd_hold, advance, reject, dcd_take, push_ok, load_dcd;
  logic [31:0]      src_data, ra_val, rb_val;
  logic [4:0]       ra_addr, rb_addr;

  p405s_apu_ins_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (ins_push_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    dcd_hold = dcd_valid_q & (APU_c405ExeBusy | hold_req);
    advance  = dcd_valid_q & APU_c405DcdValidOp & ~dcd_hold;
    // Non-APU ops are dropped even while the APU is busy.
    reject   = dcd_valid_q & ~APU_c405DcdValidOp & ~hold_req;
    dcd_take = ~dcd_valid_q | advance | reject;
    push_ok  = ins_push_valid & ins_push_ready;
    // An empty FIFO is bypassed so a push reaches decode on the next edge.
    src_data  = fifo_empty ? ins_push_data : fifo_data;
    load_dcd  = (~fifo_empty | push_ok) & dcd_take;
    fifo_pop  = ~fifo_empty & load_dcd;
    fifo_push = push_ok & ~(fifo_empty & load_dcd);

    dcd_valid_d = dcd_valid_q;
    dcd_instr_d = dcd_instr_q;
    if (load_dcd) begin
      dcd_valid_d = 1'b1;
      dcd_instr_d = src_data;
    end else if (dcd_take) begin
      dcd_valid_d = 1'b0;
    end

    ra_addr = gpr_field(dcd_instr_q, RA_LSB);
    rb_addr = gpr_field(dcd_instr_q, RB_LSB);
    ra_val  = (gpr_wr_en && gpr_wr_addr == ra_addr) ? gpr_wr_data : gpr_q[ra_addr];
    rb_val  = (gpr_wr_en && gpr_wr_addr == rb_addr) ? gpr_wr_data : gpr_q[rb_addr];

    exe_valid_d = advance;
    exe_cr_en_d = exe_cr_en_q;
    exe_ra_d    = exe_ra_q;
    exe_rb_d    = exe_rb_q;
    if (advance) begin
      exe_cr_en_d = APU_c405DcdCREn;
      exe_ra_d    = APU_c405DcdRaEn ? ra_val : '0;
      exe_rb_d    = APU_c405DcdRbEn ? rb_val : '0;
    end

    cr6_d = cr6_q;
    if (exe_valid_q && exe_cr_en_q && !flush_req && APU_c405ExeCRField == CR6_FIELD)
      cr6_d = APU_c405ExeCR;

    issue_d  = (advance && issue_q != '1) ? issue_q + 1'b1 : issue_q;
    reject_d = (reject && reject_q != '1) ? reject_q + 1'b1 : reject_q;
    busy_d   = (dcd_valid_q && APU_c405ExeBusy && busy_q != '1) ? busy_q + 1'b1 : busy_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcd_valid_q <= 1'b0;
      dcd_instr_q <= '0;
      exe_valid_q <= 1'b0;
      exe_cr_en_q <= 1'b0;
      exe_ra_q    <= '0;
      exe_rb_q    <= '0;
      cr6_q       <= '0;
      issue_q     <= '0;
      reject_q    <= '0;
      busy_q      <= '0;
    end else begin
      dcd_valid_q <= dcd_valid_d;
      dcd_instr_q <= dcd_instr_d;
      exe_valid_q <= exe_valid_d;
      exe_cr_en_q <= exe_cr_en_d;
      exe_ra_q    <= exe_ra_d;
      exe_rb_q    <= exe_rb_d;
      cr6_q       <= cr6_d;
      issue_q     <= issue_d;
      reject_q    <= reject_d;
      busy_q      <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (gpr_wr_en) gpr_q[gpr_wr_addr] <= gpr_wr_data;
  end

  assign ins_push_ready         = ~fifo_full | dcd_take;
  assign C405_apuDcdFull        = dcd_valid_q;
  assign C405_apuDcdInstruction = dcd_valid_q ? dcd_instr_q : '0;
  assign C405_apuDcdHold        = dcd_hold;
  assign C405_apuExeHold        = 1'b0;
  assign C405_apuExeFlush       = exe_valid_q & flush_req;
  assign C405_apuExeRaData      = exe_valid_q ? exe_ra_q : '0;
  assign C405_apuExeRbData      = exe_valid_q ? exe_rb_q : '0;
  assign cr6_value              = cr6_q;
  assign issue_cnt              = issue_q;
  assign reject_cnt             = reject_q;
  assign busy_cnt               = busy_q;
  assign idle                   = fifo_empty & ~dcd_valid_q & ~exe_valid_q;
endmodule
